// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: an opaque payload moves under a valid/ready handshake.
// An optional two-entry skid buffer registers inReady, and flush discards every held beat.
module pipe_stage_reg #(
    parameter int WIDTH          = 32,
    parameter bit SKID           = 1'b1,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [1:0]       occupancy
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             in_fire;
    logic             out_fire;

    // With SKID=0 the skid entry is never loaded, so its flops stay at reset and are trimmed away.
    always_comb begin
        if (SKID) begin
            inReady = ~skid_valid_q & ~flush;
        end else begin
            inReady = (~main_valid_q | outReady) & ~flush;
        end
    end

    assign in_fire   = inValid & inReady;
    assign out_fire  = main_valid_q & outReady;
    assign outValid  = main_valid_q;
    assign outData   = main_data_q;
    assign occupancy = 2'(main_valid_q) + 2'(skid_valid_q);

    // NOTE: every next-state signal takes its current value first, so no path through this block can infer a latch.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else if (SKID) begin
            if (out_fire || !main_valid_q) begin
                // The skid beat is older than anything on the input, so it is always drained first.
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_data_d  = skid_data_q;
                end else if (in_fire) begin
                    main_valid_d = 1'b1;
                    main_data_d  = inData;
                end else begin
                    main_valid_d = 1'b0;
                end
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_data_d  = inData;
            end
        end else begin
            if (inReady) begin
                main_valid_d = in_fire;
                main_data_d  = inData;
            end
        end
    end

    // NOTE: the payload is reset along with the valid bits because outData must read zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vectors and sequences, then random traffic against a queue model
// for three configurations (skid+clear, no skid, skid without clear) that share one set of inputs.
module tb_pipe_stage_reg;

    typedef logic [31:0] beat_q_t[$];

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [31:0] exp_out_data;
        logic [1:0]  exp_occ;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b, in_ready_c, out_valid_c;
    logic [31:0] out_data_a, out_data_b, out_data_c;
    logic [1:0]  occ_a, occ_b, occ_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(in_valid), .inReady(in_ready_a), .inData(in_data),
        .outValid(out_valid_a), .outReady(out_ready), .outData(out_data_a),
        .occupancy(occ_a)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(in_valid), .inReady(in_ready_b), .inData(in_data),
        .outValid(out_valid_b), .outReady(out_ready), .outData(out_data_b),
        .occupancy(occ_b)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b0)) dut_c (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(in_valid), .inReady(in_ready_c), .inData(in_data),
        .outValid(out_valid_c), .outReady(out_ready), .outData(out_data_c),
        .occupancy(occ_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    // Reference: a stage holds an ordered list of beats; capacity and ready follow the stage rules.
    function automatic logic exp_ready(input bit skid, input int held);
        if (flush) return 1'b0;
        if (skid) return held < 2;
        return (held == 0) || out_ready;
    endfunction

    task automatic model_step(input bit skid, input bit cof, input beat_q_t qi, input logic [31:0] mdi,
                              output beat_q_t qo, output logic [31:0] mdo);
        logic acc;
        logic dlv;
        qo  = qi;
        mdo = mdi;
        acc = in_valid && exp_ready(skid, qi.size());
        dlv = (qi.size() > 0) && out_ready;
        if (flush) begin
            qo.delete();
            if (cof) mdo = '0;
        end else begin
            if (dlv) void'(qo.pop_front());
            if (acc) qo.push_back(in_data);
        end
        if (qo.size() > 0) mdo = qo[0];
    endtask

    task automatic check_dut(input string tag, input bit skid, input beat_q_t q, input logic [31:0] md,
                             input logic ov, input logic ir, input logic [31:0] od, input logic [1:0] occ);
        check({tag, " outValid"}, 32'(ov), 32'(q.size() > 0));
        check({tag, " inReady"}, 32'(ir), 32'(exp_ready(skid, q.size())));
        check({tag, " occupancy"}, 32'(occ), 32'(q.size()));
        if (q.size() > 0) check({tag, " outData"}, od, q[0]);
        else if (skid) check({tag, " idle outData"}, od, md);
    endtask

    vec_t    vecs[12];
    beat_q_t qa, qb, qc;
    logic [31:0] md_a, md_b, md_c;

    initial begin
        // Streaming 0x11/0x22/0x33, then backpressure with 0xA/0xB/0xC on the skid configuration.
        vecs[0]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b0, 32'h0,  2'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h11, 2'd1};
        vecs[2]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h33, 2'd1};
        vecs[4]  = '{1'b0, 1'b1, 32'hA,  1'b0, 1'b1, 1'b0, 32'h33, 2'd0};
        vecs[5]  = '{1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 1'b1, 32'hA,  2'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 32'hA,  2'd2};
        vecs[7]  = '{1'b0, 1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 32'hA,  2'd2};
        vecs[8]  = '{1'b0, 1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 32'hA,  2'd2};
        vecs[9]  = '{1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 1'b1, 32'hB,  2'd1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hC,  2'd1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'hC,  2'd0};

        // Power-on reset.
        #1 rst = 1'b0;
        #2;
        check("reset outValid", 32'(out_valid_a), 32'd0);
        check("reset outData", out_data_a, 32'h0);
        check("reset occupancy", 32'(occ_a), 32'd0);
        check("reset inReady skid", 32'(in_ready_a), 32'd1);
        check("reset inReady noskid", 32'(in_ready_b), 32'd1);
        @(negedge clk) rst = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            @(negedge clk);
            check($sformatf("vec%0d inReady", i), 32'(in_ready_a), 32'(vecs[i].exp_in_ready));
            check($sformatf("vec%0d outValid", i), 32'(out_valid_a), 32'(vecs[i].exp_out_valid));
            check($sformatf("vec%0d outData", i), out_data_a, vecs[i].exp_out_data);
            check($sformatf("vec%0d occupancy", i), 32'(occ_a), 32'(vecs[i].exp_occ));
            step();
        end

        // Flush with two held beats and the head beat consumed in the flush cycle.
        drive(1'b0, 1'b1, 32'h55, 1'b0); step();
        drive(1'b0, 1'b1, 32'h66, 1'b0); step();
        check("pre-flush occupancy", 32'(occ_a), 32'd2);
        drive(1'b1, 1'b1, 32'h77, 1'b1);
        #1;
        check("flush inReady", 32'(in_ready_a), 32'd0);
        check("flush-cycle outValid", 32'(out_valid_a), 32'd1);
        check("flush-cycle outData", out_data_a, 32'h55);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        check("post-flush outValid", 32'(out_valid_a), 32'd0);
        check("post-flush outData cleared", out_data_a, 32'h0);
        check("post-flush occupancy", 32'(occ_a), 32'd0);
        check("noclear post-flush outValid", 32'(out_valid_c), 32'd0);
        check("noclear post-flush outData held", out_data_c, 32'h55);
        step();
        check("flush beat dropped", 32'(out_valid_a), 32'd0);

        // No-skid stage: inReady tracks outReady combinationally once full.
        drive(1'b0, 1'b1, 32'h99, 1'b0);
        #1 check("noskid empty inReady", 32'(in_ready_b), 32'd1);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1 check("noskid full inReady lo", 32'(in_ready_b), 32'd0);
        check("noskid full outData", out_data_b, 32'h99);
        out_ready = 1'b1;
        #1 check("noskid full inReady hi", 32'(in_ready_b), 32'd1);
        out_ready = 1'b0;
        #1 check("noskid full inReady lo again", 32'(in_ready_b), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 32'hB0 + 32'(k), 1'b1);
            step();
            check($sformatf("noskid stream%0d outValid", k), 32'(out_valid_b), 32'd1);
            check($sformatf("noskid stream%0d outData", k), out_data_b, 32'hB0 + 32'(k));
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        check("noskid drained", 32'(out_valid_b), 32'd0);

        // Reset mid-stream with two beats held.
        step(); step();
        drive(1'b0, 1'b1, 32'hC1, 1'b0); step();
        drive(1'b0, 1'b1, 32'hC2, 1'b0); step();
        check("pre-reset occupancy", 32'(occ_a), 32'd2);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1 rst = 1'b0;
        #1;
        check("midreset outValid", 32'(out_valid_a), 32'd0);
        check("midreset outData", out_data_a, 32'h0);
        check("midreset occupancy", 32'(occ_a), 32'd0);
        check("midreset inReady", 32'(in_ready_a), 32'd1);
        @(negedge clk) rst = 1'b1;
        step();

        // Random traffic against the queue model.
        qa.delete(); qb.delete(); qc.delete();
        md_a = '0; md_b = '0; md_c = '0;
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(15) == 0, $urandom_range(3) != 0, $urandom, $urandom_range(4) > 1);
            @(negedge clk);
            check_dut("rnd skid", 1'b1, qa, md_a, out_valid_a, in_ready_a, out_data_a, occ_a);
            check_dut("rnd noskid", 1'b0, qb, md_b, out_valid_b, in_ready_b, out_data_b, occ_b);
            check_dut("rnd noclear", 1'b1, qc, md_c, out_valid_c, in_ready_c, out_data_c, occ_c);
            model_step(1'b1, 1'b1, qa, md_a, qa, md_a);
            model_step(1'b0, 1'b1, qb, md_b, qb, md_b);
            model_step(1'b1, 1'b0, qc, md_c, qc, md_c);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
